seq_pattern_generator: RTL
==========================

// Module: seq_pattern_generator
// PURPOSE
//  Transmit-side counterpart of the team's serial pattern detectors. Serializes a
//  PAT_W-bit pattern MSB-first, repeated rep_count times, with optional zero-gap
//  bits between repetitions. Driven by a start/busy/done handshake. out_bit feeds
//  a detector's serial input (one bit per clk) for stimulus and self-test.
// PARAMETERS
//  PAT_W    4        pattern width in bits (>=2)
//  CNT_W    8        width of rep_count and pat_count
//  GAP_W    4        width of gap_len (max gap = 2**GAP_W-1 bits)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high; clears all state and outputs
//  start      in   1      request; sampled only in IDLE
//  pattern_in in   PAT_W  pattern, latched on accepted start (e.g. 4'b1011)
//  rep_count  in   CNT_W  repetitions, latched on accepted start
//  gap_len    in   GAP_W  zero bits between repetitions, latched on accepted start
//  abort      in   1      synchronous abort; return to IDLE, no done pulse
//  out_bit    out  1      serial data, registered
//  out_valid  out  1      high while out_bit carries pattern or gap bits
//  busy       out  1      high in SHIFT and GAP
//  done       out  1      one-cycle pulse after the final bit
//  pat_count  out  CNT_W  repetitions fully sent in current/last run
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): state=IDLE; out_bit=0, out_valid=0,
//    busy=0, done=0, pat_count=0; latched regs cleared. Takes effect immediately.
//  - All outputs registered; no combinational path from inputs to outputs.
//  - FSM states: IDLE, SHIFT, GAP, DONE.
//  - IDLE: start=1 at edge E0 with rep_count!=0 -> latch inputs, pat_count=0,
//    state=SHIFT; after E0: out_bit=pattern_in[PAT_W-1], out_valid=1, busy=1.
//    start=1 with rep_count==0 -> state=DONE directly (no bits, done pulse).
//  - SHIFT: after edge E0+k (k=0..PAT_W-1) out_bit = pattern[PAT_W-1-k].
//    Edge ending the last bit: pat_count+1; then
//      pat_count+1==rep_count          -> DONE
//      else gap_len==0                 -> SHIFT, next pattern MSB back-to-back
//      else                            -> GAP
//  - GAP: exactly gap_len cycles of out_bit=0, out_valid=1, busy=1; then SHIFT
//    with pattern MSB on the following cycle.
//  - DONE: exactly one cycle: done=1, busy=0, out_valid=0, out_bit=0; then IDLE.
//    start in DONE is ignored.
//  - Single run, gap 0: first bit after E0, last after E0+PAT_W-1, done after
//    E0+PAT_W. Total data cycles = rep_count*PAT_W + (rep_count-1)*gap_len.
//  - start while busy or in DONE: ignored; latched values unchanged.
//  - abort=1 in SHIFT/GAP: next state IDLE; out_valid=0, busy=0, done stays 0,
//    pat_count holds value reached. abort wins over start and over end-of-run.
//    abort in IDLE/DONE: no effect (DONE still pulses, then IDLE).
//  - pat_count saturates never: it stops at rep_count; holds until next start.
// STRUCTURE
//  - Shared package/include seq_pkg: state encodings (IDLE/SHIFT/GAP/DONE as
//    2-bit localparams), default pattern 4'b1011, default PAT_W/CNT_W/GAP_W.
//  - One sub-module: pattern_shifter (PAT_W shift register + bit index counter;
//    load, shift, last_bit flag). Gap counter, rep counter, FSM stay top-level.
// TESTING
//  1 Reset: assert reset mid-SHIFT between edges -> all outputs 0 immediately,
//    IDLE; start ignored while reset=1.
//  2 pattern=1011, rep=1, gap=0 -> out_bit 1,0,1,1 on 4 cycles after E0, valid=1
//    4 cycles, done pulse at 5th, pat_count=1.
//  3 rep=2, gap=0 -> 1,0,1,1,1,0,1,1 contiguous; rep=2, gap=2 -> 1011 00 1011,
//    valid high 10 cycles, done once, pat_count=2.
//  4 start pulsed during SHIFT with different pattern_in -> stream unchanged.
//  5 abort on 3rd bit of rep=3 run -> valid drops next cycle, no done,
//    pat_count=0; new start afterwards runs normally.
//  6 rep_count=0 start -> no valid bits, done pulse cycle after E0, pat_count=0.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared state encodings and defaults for the serial pattern generator
package seq_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        GAP   = ST_GAP,
        DONE  = ST_DONE
    } state_t;
    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_GAP_W = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1011;
endpackage

// File: rtl/pattern_shifter.sv
// pattern_shifter: holds the latched pattern, walks its bits MSB-first and flags the last bit
module pattern_shifter #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] pat_in,
    output logic             next_bit,
    output logic             first_bit,
    output logic             last_bit
);
    localparam int IW = $clog2(PAT_W);
    logic [PAT_W-1:0] pat;
    logic [PAT_W-2:0] sr;
    logic [IW-1:0]    idx;
    assign next_bit  = sr[PAT_W-2];
    assign first_bit = pat[PAT_W-1];
    assign last_bit  = idx == IW'(PAT_W - 1);
    // sr keeps the bits still to be sent after the one on the wire; it reloads after the last bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat <= '0;
            sr  <= '0;
            idx <= '0;
        end else if (load) begin
            pat <= pat_in;
            sr  <= pat_in[PAT_W-2:0];
            idx <= '0;
        end else if (shift) begin
            sr  <= last_bit ? pat[PAT_W-2:0] : sr << 1;
            idx <= last_bit ? '0 : idx + IW'(1);
        end
    end
endmodule

// File: rtl/seq_pattern_generator.sv
// seq_pattern_generator: serializes a pattern MSB-first rep_count times with optional zero gaps
module seq_pattern_generator import seq_pkg::*; #(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [CNT_W-1:0] rep_count,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             abort,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pat_count
);
    state_t           state;
    logic [CNT_W-1:0] rep_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] pat_next;
    logic             load;
    logic             shift;
    logic             next_bit;
    logic             first_bit;
    logic             last_bit;
    assign load     = state == IDLE && start;
    assign shift    = state == SHIFT && !abort;
    assign pat_next = pat_count + CNT_W'(1);
    pattern_shifter #(.PAT_W(PAT_W)) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .shift     (shift),
        .pat_in    (pattern_in),
        .next_bit  (next_bit),
        .first_bit (first_bit),
        .last_bit  (last_bit)
    );
    // control FSM with registered outputs; abort in SHIFT/GAP overrides end-of-run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rep_q     <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pat_count <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    rep_q     <= rep_count;
                    gap_q     <= gap_len;
                    pat_count <= '0;
                    if (rep_count != '0) begin
                        state     <= SHIFT;
                        out_bit   <= pattern_in[PAT_W-1];
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                SHIFT: if (abort) begin
                    state     <= IDLE;
                    out_bit   <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end else if (!last_bit) begin
                    out_bit <= next_bit;
                end else begin
                    pat_count <= pat_next;
                    if (pat_next == rep_q) begin
                        state     <= DONE;
                        out_bit   <= 1'b0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (gap_q == '0) begin
                        out_bit <= first_bit;
                    end else begin
                        state   <= GAP;
                        out_bit <= 1'b0;
                        gap_cnt <= gap_q - GAP_W'(1);
                    end
                end
                GAP: if (abort) begin
                    state     <= IDLE;
                    out_bit   <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end else if (gap_cnt == '0) begin
                    state   <= SHIFT;
                    out_bit <= first_bit;
                end else begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
